arbiter_request_queue: RTL

Two-channel requester front-end for the round-robin grant interface: each channel buffers incoming words in a small FIFO, drives its `requests` bit while it holds data, and pops one word per grant from an external 2-request arbiter. Granted words leave on a single registered output stream tagged with the channel id. The block sits between two producers and a shared sink, with the arbiter in the loop.

---
 rtl/arbiter_request_queue_if.sv | 25 ++
 rtl/arbiter_request_queue.sv | 100 ++++++++++
 2 files changed

// File: rtl/arbiter_request_queue_if.sv
// Handshake bundle between the two producers, the external arbiter and the sink.
// The slave modport is the queue side; master is the environment side.
interface arbiter_request_queue_if #(
    parameter int unsigned DATA_W = 8
);
    logic [1:0]          in_valid;
    logic [2*DATA_W-1:0] in_data;
    logic [1:0]          in_ready;
    logic [1:0]          requests;
    logic [1:0]          grants;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_id;
    logic                err;

    modport slave (
        input  in_valid, in_data, grants,
        output in_ready, requests, out_valid, out_data, out_id, err
    );

    modport master (
        output in_valid, in_data, grants,
        input  in_ready, requests, out_valid, out_data, out_id, err
    );
endinterface

// File: rtl/arbiter_request_queue.sv
// Two-channel FIFO front-end for an external 2-request arbiter, registered output stream.
// Define ARBITER_REQUEST_QUEUE_GRANT_CHECK_EN to make err flag illegal grants (sticky).
module arbiter_request_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic                    clk,
    input logic                    rst,
    arbiter_request_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic [1:0][AW-1:0] wptr_q, wptr_d;
    logic [1:0][AW-1:0] rptr_q, rptr_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         push, pop, nonempty, notfull;
    logic               legal;
    logic               gnt_id;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_id_q;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            nonempty[c] = (cnt_q[c] != '0);
            notfull[c]  = (cnt_q[c] != Full);
        end
        gnt_id = bus.grants[1];
        // Only a one-hot grant aimed at a requesting channel pops anything.
        legal  = (bus.grants == 2'b01 && nonempty[0]) || (bus.grants == 2'b10 && nonempty[1]);
        pop    = legal ? bus.grants : 2'b00;
        push   = bus.in_valid & notfull;
        for (int c = 0; c < 2; c++) begin
            wptr_d[c] = push[c] ? wptr_q[c] + AW'(1) : wptr_q[c];
            rptr_d[c] = pop[c] ? rptr_q[c] + AW'(1) : rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (push[c] && !pop[c]) begin
                cnt_d[c] = cnt_q[c] + CW'(1);
            end else if (!push[c] && pop[c]) begin
                cnt_d[c] = cnt_q[c] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= legal;
            if (legal) begin
                out_data_q <= mem_q[gnt_id][rptr_q[gnt_id]];
                out_id_q   <= gnt_id;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= bus.in_data[c*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ARBITER_REQUEST_QUEUE_GRANT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.grants != 2'b00 && !legal) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = notfull;
    assign bus.requests  = nonempty;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
endmodule
